// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake bundle between two pipeline stages.
//   valid : producer presents an entry
//   ready : consumer can take it this cycle
//   ctrl  : control payload (write enables, selects, opcodes)
//   data  : datapath payload
// master = producer side, slave = consumer side.
interface pipe_stage_skid_reg_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 12
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Generic pipeline stage register with a 2-entry skid buffer, synchronous
// flush and a saturating stall-cycle counter.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   flush     : synchronous kill of all held entries
//   stall_clr : synchronous clear of stall_cnt (wins over increment)
//   stall_cnt : cycles with dn.valid=1 and dn.ready=0, saturating
//   up        : upstream handshake (slave side), up.ready = no skid entry
//   dn        : downstream handshake (master side), driven from the main slot
module pipe_stage_skid_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_clr,
    output logic [CNT_W-1:0]      stall_cnt,
    pipe_stage_skid_reg_if.slave  up,
    pipe_stage_skid_reg_if.master dn
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic drain;
    logic load_main;

    // ready depends only on a register, so no out_ready -> in_ready path
    assign up.ready  = ~skid_valid;
    assign accept    = up.valid & ~skid_valid & ~flush;
    assign drain     = main_valid & dn.ready;
    assign load_main = ~main_valid | drain;

    assign dn.valid = main_valid;
    assign dn.ctrl  = main_ctrl;
    assign dn.data  = main_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            // data fields are left alone; only valid and ctrl are killed
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
        end else begin
            if (load_main) begin
                if (skid_valid) begin
                    // the older skid entry always goes ahead of new input
                    main_valid <= 1'b1;
                    main_ctrl  <= skid_ctrl;
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                    skid_ctrl  <= '0;
                end else if (accept) begin
                    main_valid <= 1'b1;
                    main_ctrl  <= up.ctrl;
                    main_data  <= up.data;
                end else begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                end
            end else if (accept) begin
                // main is full and not draining: park the new entry
                skid_valid <= 1'b1;
                skid_ctrl  <= up.ctrl;
                skid_data  <= up.data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (main_valid && !dn.ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;

    localparam int DW = 96;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          stall_clr;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic [15:0]   cnt16;
    logic [3:0]    cnt4;

    always #5 clk = ~clk;

    pipe_stage_skid_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up16 ();
    pipe_stage_skid_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn16 ();
    pipe_stage_skid_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up4 ();
    pipe_stage_skid_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn4 ();

    assign up16.valid = in_valid;
    assign up16.ctrl  = in_ctrl;
    assign up16.data  = in_data;
    assign dn16.ready = out_ready;
    assign up4.valid  = in_valid;
    assign up4.ctrl   = in_ctrl;
    assign up4.data   = in_data;
    assign dn4.ready  = out_ready;

    pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_clr(stall_clr),
        .stall_cnt(cnt16), .up(up16), .dn(dn16));

    pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .stall_clr(stall_clr),
        .stall_cnt(cnt4), .up(up4), .dn(dn4));

    // ---------------- reference model: FIFO of at most two entries ----------
    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        q[$];
    logic [DW-1:0] m_last;
    int            m_c16;
    int            m_c4;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        q.delete();
        m_last = '0;
        m_c16  = 0;
        m_c4   = 0;
    endtask

    task automatic model_update();
        bit     ov;
        bit     acc;
        entry_t e;
        ov = (q.size() > 0);
        if (stall_clr) begin
            m_c16 = 0;
            m_c4  = 0;
        end else if (ov && !out_ready) begin
            if (m_c16 < 65535) m_c16++;
            if (m_c4 < 15) m_c4++;
        end
        if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            if (ov && out_ready) void'(q.pop_front());
            if (acc) begin
                e.ctrl = in_ctrl;
                e.data = in_data;
                q.push_back(e);
            end
        end
        if (q.size() > 0) m_last = q[0].data;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic          ev;
        logic [CW-1:0] ec;
        ev = (q.size() > 0);
        ec = ev ? q[0].ctrl : '0;
        check("out_valid", 128'(dn16.valid), 128'(ev));
        check("out_ctrl", 128'(dn16.ctrl), 128'(ec));
        check("out_data", 128'(dn16.data), 128'(m_last));
        check("in_ready", 128'(up16.ready), 128'(q.size() < 2));
        check("stall_cnt16", 128'(cnt16), 128'(m_c16));
        check("out_valid4", 128'(dn4.valid), 128'(ev));
        check("out_data4", 128'(dn4.data), 128'(m_last));
        check("stall_cnt4", 128'(cnt4), 128'(m_c4));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic r, input logic f, input logic clr);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        flush     = f;
        stall_clr = clr;
    endtask

    // ---------------- directed vector table ---------------------------------
    typedef struct {
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          clr;
        logic          ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        logic          er;
        int            ecnt;
    } vec_t;

    vec_t vec[15];

    initial begin
        // backpressure A,B,C
        vec[0]  = '{1'b1, 12'h001, 96'hA,  1'b1, 1'b0, 1'b0, 1'b1, 12'h001, 96'hA,  1'b1, 0};
        vec[1]  = '{1'b1, 12'h002, 96'hB,  1'b0, 1'b0, 1'b0, 1'b1, 12'h001, 96'hA,  1'b0, 1};
        vec[2]  = '{1'b1, 12'h003, 96'hC,  1'b0, 1'b0, 1'b0, 1'b1, 12'h001, 96'hA,  1'b0, 2};
        vec[3]  = '{1'b1, 12'h003, 96'hC,  1'b0, 1'b0, 1'b0, 1'b1, 12'h001, 96'hA,  1'b0, 3};
        vec[4]  = '{1'b1, 12'h003, 96'hC,  1'b1, 1'b0, 1'b0, 1'b1, 12'h002, 96'hB,  1'b1, 3};
        vec[5]  = '{1'b1, 12'h003, 96'hC,  1'b1, 1'b0, 1'b0, 1'b1, 12'h003, 96'hC,  1'b1, 3};
        vec[6]  = '{1'b0, 12'h000, 96'h0,  1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 96'hC,  1'b1, 3};
        // bubble ctrl
        vec[7]  = '{1'b1, 12'hFFF, 96'h55, 1'b1, 1'b0, 1'b0, 1'b1, 12'hFFF, 96'h55, 1'b1, 3};
        vec[8]  = '{1'b0, 12'hFFF, 96'h0,  1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 96'h55, 1'b1, 3};
        // flush with main=A, skid=B, incoming D
        vec[9]  = '{1'b1, 12'h001, 96'hA,  1'b0, 1'b0, 1'b0, 1'b1, 12'h001, 96'hA,  1'b1, 3};
        vec[10] = '{1'b1, 12'h002, 96'hB,  1'b0, 1'b0, 1'b0, 1'b1, 12'h001, 96'hA,  1'b0, 4};
        vec[11] = '{1'b1, 12'h004, 96'hD,  1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 96'hA,  1'b1, 5};
        vec[12] = '{1'b1, 12'h005, 96'hE,  1'b1, 1'b0, 1'b0, 1'b1, 12'h005, 96'hE,  1'b1, 5};
        vec[13] = '{1'b0, 12'h000, 96'h0,  1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 96'hE,  1'b1, 5};
        vec[14] = '{1'b0, 12'h000, 96'h0,  1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 96'hE,  1'b1, 0};

        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        check("reset out_valid", 128'(dn16.valid), 128'(0));
        check("reset out_ctrl", 128'(dn16.ctrl), 128'(0));
        check("reset out_data", 128'(dn16.data), 128'(0));
        check("reset in_ready", 128'(up16.ready), 128'(1));
        check("reset stall_cnt", 128'(cnt16), 128'(0));
        #5 rst = 1'b0;

        // streaming 0..9
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, CW'(i + 1), DW'(i), 1'b1, 1'b0, 1'b0);
            cycle();
            check("stream data", 128'(dn16.data), 128'(i));
            check("stream ready", 128'(up16.ready), 128'(1));
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle();
        check("stream cnt", 128'(cnt16), 128'(0));

        for (int i = 0; i < 15; i++) begin
            drive(vec[i].iv, vec[i].ic, vec[i].id, vec[i].ordy, vec[i].fl, vec[i].clr);
            cycle();
            check($sformatf("vec%0d out_valid", i), 128'(dn16.valid), 128'(vec[i].ev));
            check($sformatf("vec%0d out_ctrl", i), 128'(dn16.ctrl), 128'(vec[i].ec));
            check($sformatf("vec%0d out_data", i), 128'(dn16.data), 128'(vec[i].ed));
            check($sformatf("vec%0d in_ready", i), 128'(up16.ready), 128'(vec[i].er));
            check($sformatf("vec%0d stall_cnt", i), 128'(cnt16), 128'(vec[i].ecnt));
        end

        // counter saturation
        drive(1'b1, 12'h07, 96'h77, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle();
        check("sat cnt4", 128'(cnt4), 128'(15));
        check("sat cnt16", 128'(cnt16), 128'(20));
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle();
        check("clr cnt4", 128'(cnt4), 128'(0));
        check("clr cnt16", 128'(cnt16), 128'(0));

        // fill skid, build stall_cnt=5, then async reset between edges
        drive(1'b1, 12'h08, 96'h88, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle();
        check("prerst cnt", 128'(cnt16), 128'(5));
        check("prerst in_ready", 128'(up16.ready), 128'(0));
        #2 rst = 1'b1;
        #1;
        check("rst out_valid", 128'(dn16.valid), 128'(0));
        check("rst out_ctrl", 128'(dn16.ctrl), 128'(0));
        check("rst out_data", 128'(dn16.data), 128'(0));
        check("rst in_ready", 128'(up16.ready), 128'(1));
        check("rst cnt", 128'(cnt16), 128'(0));
        #2 rst = 1'b0;
        model_reset();
        drive(1'b1, 12'h09, 96'h99, 1'b1, 1'b0, 1'b0);
        cycle();
        check("postrst out_valid", 128'(dn16.valid), 128'(1));
        check("postrst out_data", 128'(dn16.data), 128'(96'h99));

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 99) < 60), CW'($urandom),
                  {$urandom, $urandom, $urandom},
                  1'($urandom_range(0, 99) < 65),
                  1'($urandom_range(0, 99) < 4),
                  1'($urandom_range(0, 99) < 2));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
